// File: rtl/multicycle_alu_if.sv
// Operand/result bundle between the control FSM and the multi-cycle ALU.
// The master side issues requests and consumes results; the slave side is the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic               zero;
    logic               div_by_zero;

    modport master (
        output start, op, a, b, shamt,
        input  busy, done, result, hi, zero, div_by_zero
    );

    modport slave (
        input  start, op, a, b, shamt,
        output busy, done, result, hi, zero, div_by_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU for the multi-cycle MIPS datapath. Logic, shift and compare
// ops finish in one clock; MULT (shift-add) and DIV (restoring) iterate for
// WIDTH clocks and deliver a HI/LO pair. Results only change on completion.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    multicycle_alu_if.slave  bus
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SRA   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SUBEQ = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SUBNE = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1101;

    // The counter holds 0..WIDTH; the last iteration runs while it reads WIDTH-1.
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH - 1);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_reg, state_next;
    logic [SHAMT_W:0]   cnt_reg, cnt_next;
    // opnd: multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    // acc_hi/acc_lo: partial product / multiplier, or remainder / dividend-quotient
    logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0]   acc_lo_reg, acc_lo_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic               zero_reg, zero_next;
    logic               dbz_reg, dbz_next;
    logic               done_reg, done_next;

    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_step, mul_lo_step;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   div_hi_step, div_lo_step;
    logic               accept;

    assign accept = bus.start && (state_reg == IDLE);

    // Single-cycle result for the opcode currently on the bus.
    always_comb begin
        alu_out = '0;
        case (bus.op)
            OP_ADD:             alu_out = bus.a + bus.b;
            OP_SUBEQ, OP_SUBNE: alu_out = bus.a - bus.b;
            OP_AND:             alu_out = bus.a & bus.b;
            OP_OR:              alu_out = bus.a | bus.b;
            OP_NOR:             alu_out = ~(bus.a | bus.b);
            OP_SLT:             alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU:            alu_out = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:             alu_out = bus.a << bus.shamt;
            OP_SRL:             alu_out = bus.a >> bus.shamt;
            OP_SRA:             alu_out = $signed(bus.a) >>> bus.shamt;
            default:            alu_out = '0;
        endcase
    end

    // One iteration step of each engine, computed from the working registers.
    always_comb begin
        // Shift-add: conditionally add multiplicand to the upper half, then
        // shift the whole {carry, acc_hi, acc_lo} right by one.
        mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_hi_step = mul_sum[WIDTH:1];
        mul_lo_step = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        // Restoring division: bring in the next dividend bit, trial-subtract.
        div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_trial   = div_shift - {1'b0, opnd_reg};
        div_fits    = ~div_trial[WIDTH];
        div_hi_step = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_step = {acc_lo_reg[WIDTH-2:0], div_fits};
    end

    // Next-state and datapath update; result registers move only on completion.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        opnd_next   = opnd_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        result_next = result_reg;
        hi_next     = hi_reg;
        zero_next   = zero_reg;
        dbz_next    = dbz_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MULT) begin
                        state_next  = MUL;
                        cnt_next    = '0;
                        opnd_next   = bus.a;
                        acc_hi_next = '0;
                        acc_lo_next = bus.b;
                    end else if (bus.op == OP_DIV && bus.b != '0) begin
                        state_next  = DIV;
                        cnt_next    = '0;
                        opnd_next   = bus.b;
                        acc_hi_next = '0;
                        acc_lo_next = bus.a;
                    end else if (bus.op == OP_DIV) begin
                        // Zero divisor: report immediately without iterating.
                        result_next = '1;
                        hi_next     = bus.a;
                        zero_next   = 1'b0;
                        dbz_next    = 1'b1;
                        done_next   = 1'b1;
                    end else begin
                        result_next = alu_out;
                        hi_next     = '0;
                        zero_next   = (alu_out == '0) ^ (bus.op == OP_SUBNE);
                        dbz_next    = 1'b0;
                        done_next   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_hi_next = mul_hi_step;
                acc_lo_next = mul_lo_step;
                cnt_next    = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    state_next  = IDLE;
                    result_next = mul_lo_step;
                    hi_next     = mul_hi_step;
                    zero_next   = (mul_lo_step == '0);
                    dbz_next    = 1'b0;
                    done_next   = 1'b1;
                end
            end
            DIV: begin
                acc_hi_next = div_hi_step;
                acc_lo_next = div_lo_step;
                cnt_next    = cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_LAST) begin
                    state_next  = IDLE;
                    result_next = div_lo_step;
                    hi_next     = div_hi_step;
                    zero_next   = (div_lo_step == '0);
                    dbz_next    = 1'b0;
                    done_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and iteration counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Working registers and visible result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            opnd_reg   <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            result_reg <= '0;
            hi_reg     <= '0;
            zero_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            opnd_reg   <= opnd_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            result_reg <= result_next;
            hi_reg     <= hi_next;
            zero_reg   <= zero_next;
            dbz_reg    <= dbz_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.result      = result_reg;
    assign bus.hi          = hi_reg;
    assign bus.zero        = zero_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=32 and WIDTH=8.
module tb_multicycle_alu;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SRA   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SUBEQ = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SUBNE = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        dbz;
        int          lat;
        int          busy_cyc;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   busy32 = 0;
    int   busy8 = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;

    multicycle_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus32();
    multicycle_alu_if #(.WIDTH(8),  .SHAMT_W(3)) bus8();

    multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut32 (.CLK(clk), .RESET(rst), .bus(bus32.slave));
    multicycle_alu #(.WIDTH(8),  .SHAMT_W(3)) dut8  (.CLK(clk), .RESET(rst), .bus(bus8.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(string name, logic [31:0] res, logic [31:0] hi,
                                logic zero, logic dbz, int lat, int bcyc);
        exp_t e;
        e.name = name; e.res = res; e.hi = hi; e.zero = zero; e.dbz = dbz;
        e.lat = lat; e.busy_cyc = bcyc; e.acc_cyc = 0;
        return e;
    endfunction

    // Reference model for the 8-bit instance, written with plain operators.
    function automatic exp_t ref8(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [2:0] sh);
        exp_t        e;
        logic [15:0] p;
        logic [7:0]  r;
        logic [7:0]  h;
        h = 8'h00;
        e = mk("ref8", 32'h0, 32'h0, 1'b0, 1'b0, 1, 0);
        case (op)
            OP_ADD:             r = a + b;
            OP_SUBEQ, OP_SUBNE: r = a - b;
            OP_AND:             r = a & b;
            OP_OR:              r = a | b;
            OP_NOR:             r = ~(a | b);
            OP_SLT:             r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            OP_SLTU:            r = (a < b) ? 8'd1 : 8'd0;
            OP_SLL:             r = a << sh;
            OP_SRL:             r = a >> sh;
            OP_SRA:             r = $signed(a) >>> sh;
            OP_MULT: begin
                p = a * b; r = p[7:0]; h = p[15:8];
                e.lat = 9; e.busy_cyc = 8;
            end
            OP_DIV: begin
                if (b == 8'd0) begin
                    r = 8'hFF; h = a; e.dbz = 1'b1;
                end else begin
                    r = a / b; h = a % b; e.lat = 9; e.busy_cyc = 8;
                end
            end
            default:            r = 8'h00;
        endcase
        e.res  = {24'h0, r};
        e.hi   = {24'h0, h};
        e.zero = (r == 8'h00) ^ (op == OP_SUBNE);
        return e;
    endfunction

    task automatic expect_txn(exp_t e, logic [31:0] r, logic [31:0] h, logic z, logic d,
                              logic bsy, int bcnt);
        check({e.name, ".result"}, r, e.res);
        check({e.name, ".hi"}, h, e.hi);
        check({e.name, ".zero"}, {31'h0, z}, {31'h0, e.zero});
        check({e.name, ".div_by_zero"}, {31'h0, d}, {31'h0, e.dbz});
        check({e.name, ".latency"}, cyc - e.acc_cyc, e.lat);
        check({e.name, ".busy_cycles"}, bcnt, e.busy_cyc);
        check({e.name, ".busy_with_done"}, {31'h0, bsy}, 32'h0);
        $display("txn %s result=0x%08h hi=0x%08h zero=%0b dbz=%0b lat=%0d busy=%0d",
                 e.name, r, h, z, d, cyc - e.acc_cyc, bcnt);
    endtask

    // Monitor for the 32-bit instance: pops an expectation on every done.
    always @(negedge clk) begin
        if (rst) begin
            busy32 = 0;
        end else begin
            if (bus32.busy) busy32++;
            if (bus32.done) begin
                if (q32.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done32: actual=done required=no done");
                end else begin
                    m32 = q32.pop_front();
                    expect_txn(m32, bus32.result, bus32.hi, bus32.zero, bus32.div_by_zero,
                               bus32.busy, busy32);
                end
                busy32 = 0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            busy8 = 0;
        end else begin
            if (bus8.busy) busy8++;
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done8: actual=done required=no done");
                end else begin
                    m8 = q8.pop_front();
                    expect_txn(m8, {24'h0, bus8.result}, {24'h0, bus8.hi}, bus8.zero,
                               bus8.div_by_zero, bus8.busy, busy8);
                end
                busy8 = 0;
            end
        end
    end

    task automatic issue32(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh, exp_t e);
        e.acc_cyc = cyc;
        q32.push_back(e);
        bus32.op = op; bus32.a = a; bus32.b = b; bus32.shamt = sh; bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic issue8(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [2:0] sh, exp_t e);
        e.acc_cyc = cyc;
        q8.push_back(e);
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.shamt = sh; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (q32.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q32.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout32: actual=%0d pending required=0 pending", q32.size());
            q32.delete();
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q8.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout8: actual=%0d pending required=0 pending", q8.size());
            q8.delete();
        end
    endtask

    initial begin
        logic [3:0] rop;
        logic [7:0] ra, rb;
        logic [2:0] rsh;
        exp_t       re;
        int         n;

        bus32.start = 1'b0; bus32.op = 4'h0; bus32.a = '0; bus32.b = '0; bus32.shamt = '0;
        bus8.start  = 1'b0; bus8.op  = 4'h0; bus8.a  = '0; bus8.b  = '0; bus8.shamt  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.busy", {31'h0, bus32.busy}, 32'h0);
        check("reset.done", {31'h0, bus32.done}, 32'h0);
        check("reset.result", bus32.result, 32'h0);
        check("reset.hi", bus32.hi, 32'h0);
        check("reset.zero", {31'h0, bus32.zero}, 32'h0);
        check("reset.dbz", {31'h0, bus32.div_by_zero}, 32'h0);
        check("reset8.result", {24'h0, bus8.result}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops, back to back.
        issue32(OP_ADD,   32'd5, 32'd7, 5'd0, mk("add_5_7",  32'd12, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SUBNE, 32'd9, 32'd9, 5'd0, mk("bne_9_9",  32'd0,  32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SUBEQ, 32'd9, 32'd9, 5'd0, mk("beq_9_9",  32'd0,  32'h0, 1'b1, 1'b0, 1, 0));
        issue32(OP_SUBEQ, 32'd3, 32'd5, 5'd0, mk("sub_3_5",  32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SRA, 32'h80000000, 32'h0, 5'd4, mk("sra_4", 32'hF8000000, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SRL, 32'h80000000, 32'h0, 5'd4, mk("srl_4", 32'h08000000, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SLL, 32'h00000001, 32'h0, 5'd31, mk("sll_31", 32'h80000000, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SLT,  32'hFFFFFFFF, 32'd1, 5'd0, mk("slt_m1_1",  32'd1, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, mk("sltu_m1_1", 32'd0, 32'h0, 1'b1, 1'b0, 1, 0));
        issue32(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, mk("and", 32'hF000F000, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, mk("or",  32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_NOR, 32'h0, 32'h0, 5'd0, mk("nor_0_0", 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1, 0));
        issue32(OP_NOP, 32'd5, 32'd7, 5'd0, mk("nop", 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        issue32(4'b1001, 32'd5, 32'd7, 5'd0, mk("undef_1001", 32'h0, 32'h0, 1'b1, 1'b0, 1, 0));
        wait_idle32();

        // Iterative ops and the zero-divisor fast path.
        issue32(OP_MULT, 32'hFFFFFFFF, 32'd2, 5'd0, mk("mult_m1_2", 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 33, 32));
        wait_idle32();
        issue32(OP_MULT, 32'd0, 32'd5, 5'd0, mk("mult_0_5", 32'h0, 32'h0, 1'b1, 1'b0, 33, 32));
        wait_idle32();
        issue32(OP_DIV, 32'd100, 32'd7, 5'd0, mk("div_100_7", 32'd14, 32'd2, 1'b0, 1'b0, 33, 32));
        wait_idle32();
        issue32(OP_DIV, 32'd7, 32'd100, 5'd0, mk("div_7_100", 32'd0, 32'd7, 1'b1, 1'b0, 33, 32));
        wait_idle32();
        issue32(OP_DIV, 32'hFFFFFFFF, 32'd1, 5'd0, mk("div_m1_1", 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 33, 32));
        wait_idle32();
        issue32(OP_DIV, 32'd100, 32'd0, 5'd0, mk("div_100_0", 32'hFFFFFFFF, 32'd100, 1'b0, 1'b1, 1, 0));
        issue32(OP_ADD, 32'd5, 32'd7, 5'd0, mk("add_after_dbz", 32'd12, 32'h0, 1'b0, 1'b0, 1, 0));
        wait_idle32();

        // A start pulse while busy must be ignored.
        issue32(OP_MULT, 32'h12345678, 32'h10, 5'd0, mk("mult_ignore_start", 32'h23456780, 32'h1, 1'b0, 1'b0, 33, 32));
        repeat (5) @(negedge clk);
        bus32.op = OP_ADD; bus32.a = 32'd1; bus32.b = 32'd1; bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_idle32();

        // New request accepted in the done cycle.
        issue32(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, mk("mult_m1_m1", 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 32));
        n = 0;
        while (!bus32.done && n < 100) begin @(negedge clk); n++; end
        if (!bus32.done) begin
            total++; bad++;
            $display("FAIL b2b_wait: actual=no done required=done");
        end
        issue32(OP_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, mk("add_in_done_cycle", 32'h80000000, 32'h0, 1'b0, 1'b0, 1, 0));
        wait_idle32();

        // Reset at iteration 10 of a DIV: no done, outputs cleared.
        bus32.op = OP_DIV; bus32.a = 32'd100; bus32.b = 32'd7; bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset.busy", {31'h0, bus32.busy}, 32'h0);
        check("midreset.done", {31'h0, bus32.done}, 32'h0);
        check("midreset.result", bus32.result, 32'h0);
        check("midreset.hi", bus32.hi, 32'h0);
        check("midreset.zero", {31'h0, bus32.zero}, 32'h0);
        check("midreset.dbz", {31'h0, bus32.div_by_zero}, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // WIDTH=8 instance: directed vectors, then a short random regression.
        issue8(OP_MULT, 8'hFF, 8'hFF, 3'd0, mk("mult8_ff_ff", 32'h01, 32'hFE, 1'b0, 1'b0, 9, 8));
        wait_idle8();
        issue8(OP_DIV, 8'd200, 8'd3, 3'd0, mk("div8_200_3", 32'd66, 32'd2, 1'b0, 1'b0, 9, 8));
        wait_idle8();
        issue8(OP_DIV, 8'd200, 8'd0, 3'd0, mk("div8_200_0", 32'hFF, 32'd200, 1'b0, 1'b1, 1, 0));
        issue8(OP_SRA, 8'h80, 8'h00, 3'd3, mk("sra8_3", 32'hF0, 32'h0, 1'b0, 1'b0, 1, 0));
        wait_idle8();
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rsh = 3'($urandom_range(0, 7));
            re  = ref8(rop, ra, rb, rsh);
            re.name = $sformatf("rnd8_%0d_op%0h_a%02h_b%02h_s%0d", i, rop, ra, rb, rsh);
            issue8(rop, ra, rb, rsh, re);
            wait_idle8();
        end

        wait_idle32();
        wait_idle8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
